// File: rtl/cm_sketch_pkg.sv
// Shared types for the count-min sketch consumer blocks: default widths,
// the buffered report entry and the reporter FSM states.
package cm_sketch_pkg;

    localparam int CM_ADDR_SIZE = 28;
    localparam int CM_CNT_SIZE  = 32;

    typedef struct packed {
        logic [CM_ADDR_SIZE-1:0] addr;
        logic [CM_CNT_SIZE-1:0]  cnt;
    } cm_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/cm_hot_addr_reporter_if.sv
// Result stream from the sketch and report stream to the hot-page consumer.
interface cm_hot_addr_reporter_if #(
    parameter int ADDR_SIZE = 28,
    parameter int CNT_SIZE  = 32
);
    // in_*: no backpressure, in_valid is a one-cycle pulse per result.
    // out_*: a transfer happens on a cycle where out_valid && out_ready;
    // out_addr/out_cnt are stable while out_valid is high and not taken.
    logic                 in_valid;
    logic [ADDR_SIZE-1:0] in_addr;
    logic [CNT_SIZE-1:0]  in_cnt;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_SIZE-1:0] out_addr;
    logic [CNT_SIZE-1:0]  out_cnt;

    modport slave (
        input  in_valid, in_addr, in_cnt, out_ready,
        output out_valid, out_addr, out_cnt
    );

    modport master (
        output in_valid, in_addr, in_cnt, out_ready,
        input  out_valid, out_addr, out_cnt
    );
endinterface

// File: rtl/cm_fwft_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle. rdata reads as zero while empty.
module cm_fwft_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 60
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: only entries below count are ever visible.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cm_hot_addr_reporter.sv
// Filters sketch results by threshold, suppresses recently reported
// addresses and buffers the survivors for the hot-page consumer.
module cm_hot_addr_reporter
    import cm_sketch_pkg::*;
#(
    parameter int ADDR_SIZE = CM_ADDR_SIZE,
    parameter int CNT_SIZE  = CM_CNT_SIZE,
    parameter int DEPTH     = 16,
    parameter int DEDUP     = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CNT_SIZE-1:0]          threshold,
    input  logic                         enable,
    input  logic                         clear,
    cm_hot_addr_reporter_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [15:0]                  drop_cnt,
    output logic                         busy,
    output rpt_state_t                   state
);
    localparam int EW = ADDR_SIZE + CNT_SIZE;

    rpt_state_t           state_q;
    rpt_state_t           state_d;
    logic                 s0_valid;
    logic [ADDR_SIZE-1:0] s0_addr;
    logic [CNT_SIZE-1:0]  s0_cnt;
    logic [ADDR_SIZE-1:0] hist_addr [DEDUP];
    logic [DEDUP-1:0]     hist_vld;
    logic                 hit;
    logic                 qualify;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        fifo_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_valid <= 1'b0;
            s0_addr  <= '0;
            s0_cnt   <= '0;
        end else begin
            s0_valid <= bus.in_valid && !clear;
            s0_addr  <= bus.in_addr;
            s0_cnt   <= bus.in_cnt;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEDUP; i++) begin
            if (hist_vld[i] && (hist_addr[i] == s0_addr)) hit = 1'b1;
        end
    end

    // clear wins over everything, including a pop the consumer offers.
    assign qualify = s0_valid && (state_q == RUN) && (s0_cnt >= threshold) && !clear;
    assign pop     = bus.out_valid && bus.out_ready && !clear;
    assign push    = qualify && !hit && (!fifo_full || pop);
    assign drop    = qualify && !hit && fifo_full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_vld <= '0;
        end else if (clear) begin
            hist_vld <= '0;
        end else if (push) begin
            hist_vld[0] <= 1'b1;
            for (int i = 1; i < DEDUP; i++) hist_vld[i] <= hist_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            hist_addr[0] <= s0_addr;
            for (int i = 1; i < DEDUP; i++) hist_addr[i] <= hist_addr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (clear) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN:     if (!enable) state_d = DRAIN;
                DRAIN: begin
                    if (enable)          state_d = RUN;
                    else if (fifo_empty) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);

    cm_fwft_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .push  (push),
        .wdata ({s0_addr, s0_cnt}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_addr  = fifo_rdata[EW-1:CNT_SIZE];
    assign bus.out_cnt   = fifo_rdata[CNT_SIZE-1:0];

endmodule

// File: doc/cm_hot_addr_reporter.md
# cm_hot_addr_reporter

Consumer-side block for the count-min sketch result stream. It takes the sketch's per-access (address, estimated count) output, which has no backpressure. It keeps only addresses whose count reaches a programmable threshold and suppresses repeats of recently reported addresses. Surviving entries are buffered in a FIFO and presented to the downstream hot-page consumer (sorted CAM / host reader) over a valid/ready handshake.

## Interface
- ADDR_SIZE, 28, address width; matches the sketch's ADDR_SIZE.
- CNT_SIZE, 32, count width; matches the sketch's CNT_SIZE.
- DEPTH, 16, report FIFO entries; power of two, ≥2.
- DEDUP, 4, number of recently reported addresses held for duplicate suppression; ≥1.

Ports (reset rstn, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  sketch output_valid; one-cycle pulse per result, no backpressure
- in_addr  in  ADDR_SIZE  sketch output_addr
- in_cnt  in  CNT_SIZE  sketch output_cnt (min estimate)
- threshold  in  CNT_SIZE  report when in_cnt ≥ threshold; quasi-static
- enable  in  1  level; accept new results while high
- clear  in  1  synchronous one-cycle flush
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_addr  out  ADDR_SIZE  head address; 0 when empty
- out_cnt  out  CNT_SIZE  head count; 0 when empty
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy
- drop_cnt  out  16  results lost to FIFO full; saturates at 0xFFFF
- busy  out  1  state ≠ IDLE

## Operation
- Stage 0: in_valid, in_addr and in_cnt are registered unconditionally.
- Stage 1 qualifies the registered result. A result qualifies when the state is RUN and cnt ≥ threshold (unsigned compare).
- Dedup check: a qualifying address is compared against all valid history entries.
  - Hit: the result is discarded silently. History is unchanged.
- Push: on a miss, the result is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - A pushed address is shifted into the history; the oldest entry is evicted and history valid bits fill from reset.
- Drop: on a miss with the FIFO full and no pop, the result is dropped and drop_cnt increments (saturating). A dropped address is not entered into the history.
- Output is first-word-fall-through: out_valid = !empty. A pop occurs when out_valid && out_ready.
- FSM states:
  - IDLE: no acceptance. Goes to RUN when enable=1.
  - RUN: accepting results. Goes to DRAIN when enable=0.
  - DRAIN: no acceptance; the FIFO keeps emptying. Goes to RUN when enable=1. Goes to IDLE when the FIFO is empty and enable=0.
- clear has the highest priority. It empties the FIFO, invalidates the history, zeroes drop_cnt, discards the stage-0 result, and forces the state to IDLE. A pop in the same cycle is ignored.
- Threshold 0 qualifies every result. in_cnt = 2^CNT_SIZE−1 always qualifies.

## Timing
- Reset values: out_valid 0, out_addr 0, out_cnt 0, fill_level 0, drop_cnt 0, busy 0, state IDLE, history all invalid.
- Latency from in_valid in cycle N (FIFO empty, RUN) to out_valid=1 with data in cycle N+2.
- Back-to-back in_valid every cycle is sustained.
- The history update from a cycle-k push is visible to the dedup compare of the result in cycle k+1. An identical address on consecutive cycles is reported once.
- fill_level reflects pushes and pops on the following cycle. With a simultaneous push and pop it is unchanged.
- Enable is sampled per cycle. A result already in stage 0 when the state leaves RUN is discarded.
- Reset mid-operation clears everything asynchronously. No output is valid until a new push.

## Structure
- Shared package cm_sketch_pkg holds:
  - ADDR_SIZE/CNT_SIZE defaults
  - typedef struct {addr, cnt} cm_entry_t
  - typedef enum {IDLE, RUN, DRAIN} rpt_state_t
- Sub-module cm_fwft_fifo (DEPTH, entry width): pointer wrap, full/empty, count, simultaneous push/pop. Top level holds the pipeline register, the compare, the history shift register, the FSM and the drop counter.

## Test plan
- Threshold test:
  - Stimulus: threshold=5, enable=1, results (0x100,4), (0x101,5), (0x102,9).
  - Response: reports 0x101/5 then 0x102/9. First out_valid two cycles after the 0x101 in_valid.
- Dedup test (DEDUP=4, out_ready=1):
  - Stimulus: addresses A,A,B,C,D,E,A consecutively, all qualifying.
  - Response: reports A,B,C,D,E,A; the second A is suppressed; the final A is reported after its eviction.
- Overflow test (DEPTH=16, out_ready=0):
  - Stimulus: 20 distinct qualifying addresses.
  - Response: fill_level=16, drop_cnt=4.
  - Then out_ready=1: the first 16 addresses drain in order and fill_level returns to 0.
- Full-with-pop test: FIFO full, out_ready=1, and a new qualifying result arrives.
  - Response: the push is accepted, fill_level stays 16, drop_cnt is unchanged.
- Drain test: 3 entries queued, enable dropped, further in_valid.
  - Response: nothing new is accepted, the 3 entries drain, and busy=0 one cycle after empty.
  - clear mid-stream: out_valid=0 next cycle and drop_cnt=0.
- Reset test: assert rstn=0 asynchronously mid-burst.
  - Response: all outputs go to 0 immediately; after release, normal operation resumes once enable=1.
